// File: rtl/me_pkg.sv
// me_pkg: shared FSM state type and sizing helpers for the motion-estimation
// SAD array (me_sad_array) and its pipelined adder tree.
package me_pkg;

    // Run phases of the SAD array controller.
    typedef enum logic [2:0] {
        IDLE,
        LOAD_CUR,
        FILL,
        SEARCH,
        DRAIN
    } state_e;

    // Width of a full-block SAD: pixel width plus one bit per adder-tree level.
    function automatic int sad_width(input int blk_dim, input int pix_w);
        return pix_w + $clog2(blk_dim * blk_dim);
    endfunction

    // Accept edge to sad_valid: SPR shift, AD register, tree levels, output register.
    function automatic int pipe_lat(input int blk_dim);
        return 2 + $clog2(blk_dim * blk_dim);
    endfunction

endpackage

// File: rtl/sad_adder_tree.sv
// sad_adder_tree: pipelined binary reduction of N_IN unsigned IN_W-bit values.
// One register level per tree level; every level widens by one bit so the sum
// can never overflow. All levels advance together on en_i.
module sad_adder_tree #(
    parameter int  N_IN   = 256,
    parameter int  IN_W   = 8,
    localparam int LEVELS = $clog2(N_IN),
    localparam int OUT_W  = IN_W + LEVELS
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en_i,
    input  logic [N_IN*IN_W-1:0] data_i,
    output logic [OUT_W-1:0]     sum_o
);

    for (genvar l = 0; l <= LEVELS; l++) begin : g_lvl
        localparam int NODES = N_IN >> l;
        localparam int W     = IN_W + l;

        logic [W-1:0] node [NODES];

        if (l == 0) begin : g_leaf
            for (genvar i = 0; i < NODES; i++) begin : g_in
                assign node[i] = data_i[i*IN_W +: IN_W];
            end
        end else begin : g_add
            // Pairwise sums of the previous level, held while the pipeline is frozen.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    // NOTE: pipeline arrays are cleared on reset so a run after an abort cannot see stale partial sums.
                    for (int i = 0; i < NODES; i++) node[i] <= '0;
                end else if (en_i) begin
                    // NOTE: non-blocking assignments so every level samples the pre-edge value of the level below.
                    for (int i = 0; i < NODES; i++)
                        node[i] <= W'(g_lvl[l-1].node[2*i]) + W'(g_lvl[l-1].node[2*i+1]);
                end
            end
        end
    end

    assign sum_o = g_lvl[LEVELS].node[0];

endmodule

// File: rtl/me_sad_array.sv
// me_sad_array: PE matrix for integer-pel vertical motion search.
// Holds the current block in CPR, slides a BLK_DIM-row search window through
// SPR and produces one full-block SAD per vertical candidate through an
// absolute-difference stage and a pipelined adder tree.
// Optional build macro ME_MIN_TRACK_EN adds best_sad/best_idx minimum tracking.
module me_sad_array
    import me_pkg::*;
#(
    parameter int  BLK_DIM  = 16,
    parameter int  PIX_W    = 8,
    parameter int  SRCH_MAX = 48,
    localparam int SAD_W    = sad_width(BLK_DIM, PIX_W),
    localparam int IDX_W    = $clog2(SRCH_MAX),
    localparam int CFG_W    = $clog2(SRCH_MAX + 1),
    localparam int ROW_W    = BLK_DIM * PIX_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CFG_W-1:0] cfg_srch_rows,
    input  logic             cur_valid,
    output logic             cur_ready,
    input  logic [ROW_W-1:0] cur_row,
    input  logic             srch_valid,
    output logic             srch_ready,
    input  logic [ROW_W-1:0] srch_row,
    output logic             sad_valid,
    input  logic             sad_ready,
    output logic [SAD_W-1:0] sad,
    output logic [IDX_W-1:0] sad_idx,
`ifdef ME_MIN_TRACK_EN
    output logic [SAD_W-1:0] best_sad,
    output logic [IDX_W-1:0] best_idx,
`endif
    output logic             busy,
    output logic             done
);

    localparam int NPIX  = BLK_DIM * BLK_DIM;
    localparam int LAT   = pipe_lat(BLK_DIM);
    localparam int ROWIW = $clog2(BLK_DIM);

    state_e               state_q, state_d;
    logic [CFG_W-1:0]     cnt_q, cnt_d;
    logic [CFG_W-1:0]     rows_q, rows_d;
    logic [IDX_W-1:0]     last_idx_q, last_idx_d;
    logic                 done_q, done_d;
    logic [CFG_W-1:0]     rows_clamped;

    logic [ROW_W-1:0]     cpr_q [BLK_DIM];
    logic [ROW_W-1:0]     spr_q [BLK_DIM];
    logic [NPIX*PIX_W-1:0] ad_q, ad_d;
    logic                 vld_q [LAT];
    logic [IDX_W-1:0]     idx_q [LAT];
    logic [SAD_W-1:0]     tree_sum;
    logic [SAD_W-1:0]     sad_q;
    logic [IDX_W-1:0]     sad_idx_q;
    logic                 sad_valid_q;

    logic                 stall, adv, cur_acc, srch_acc, launch, sad_hs;
    logic [IDX_W-1:0]     launch_idx;

    // A stall (result waiting, not taken) freezes SPR, counters and every pipeline stage.
    assign stall      = sad_valid_q & ~sad_ready;
    assign adv        = ~stall;
    assign cur_ready  = (state_q == LOAD_CUR);
    assign srch_ready = ((state_q == FILL) || (state_q == SEARCH)) && adv;
    assign cur_acc    = cur_ready & cur_valid;
    assign srch_acc   = srch_ready & srch_valid;
    assign launch     = srch_acc && (state_q == SEARCH);
    assign sad_hs     = sad_valid_q & sad_ready;
    // The (BLK_DIM+v)-th search row completes the window for candidate v.
    assign launch_idx = IDX_W'(cnt_q - CFG_W'(BLK_DIM - 1));

    assign rows_clamped = (cfg_srch_rows < CFG_W'(BLK_DIM))  ? CFG_W'(BLK_DIM)  :
                          (cfg_srch_rows > CFG_W'(SRCH_MAX)) ? CFG_W'(SRCH_MAX) :
                          cfg_srch_rows;

    // Run controller: next state, row counter, run geometry and done pulse.
    always_comb begin
        // NOTE: every variable gets a default before the case so no path can infer a latch.
        state_d    = state_q;
        cnt_d      = cnt_q;
        rows_d     = rows_q;
        last_idx_d = last_idx_q;
        done_d     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = LOAD_CUR;
                    cnt_d      = '0;
                    rows_d     = rows_clamped;
                    last_idx_d = IDX_W'(rows_clamped - CFG_W'(BLK_DIM));
                end
            end
            LOAD_CUR: begin
                if (cur_acc) begin
                    if (cnt_q == CFG_W'(BLK_DIM - 1)) begin
                        state_d = FILL;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            FILL: begin
                if (srch_acc) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CFG_W'(BLK_DIM - 2)) state_d = SEARCH;
                end
            end
            SEARCH: begin
                if (srch_acc) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == rows_q - 1'b1) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (sad_hs && (sad_idx_q == last_idx_q)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Controller registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            rows_q     <= '0;
            last_idx_q <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rows_q     <= rows_d;
            last_idx_q <= last_idx_d;
            done_q     <= done_d;
        end
    end

    // CPR: current-block row k lands in row k.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < BLK_DIM; r++) cpr_q[r] <= '0;
        end else if (cur_acc) begin
            cpr_q[cnt_q[ROWIW-1:0]] <= cur_row;
        end
    end

    // SPR: stage 0, window slides up one row per accepted search row.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < BLK_DIM; r++) spr_q[r] <= '0;
        end else if (srch_acc) begin
            for (int r = 0; r < BLK_DIM - 1; r++) spr_q[r] <= spr_q[r+1];
            spr_q[BLK_DIM-1] <= srch_row;
        end
    end

    // Per-PE absolute difference between the window and the current block.
    always_comb begin
        ad_d = '0;
        for (int r = 0; r < BLK_DIM; r++) begin
            for (int c = 0; c < BLK_DIM; c++) begin
                ad_d[(r*BLK_DIM + c)*PIX_W +: PIX_W] =
                    (cpr_q[r][c*PIX_W +: PIX_W] > spr_q[r][c*PIX_W +: PIX_W])
                        ? cpr_q[r][c*PIX_W +: PIX_W] - spr_q[r][c*PIX_W +: PIX_W]
                        : spr_q[r][c*PIX_W +: PIX_W] - cpr_q[r][c*PIX_W +: PIX_W];
            end
        end
    end

    // Stage 1: AD register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ad_q <= '0;
        end else if (adv) begin
            ad_q <= ad_d;
        end
    end

    sad_adder_tree #(
        .N_IN (NPIX),
        .IN_W (PIX_W)
    ) u_tree (
        .clk    (clk),
        .rst_n  (rst_n),
        .en_i   (adv),
        .data_i (ad_q),
        .sum_o  (tree_sum)
    );

    // Valid/index shadow pipeline, aligned with the data stages.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < LAT; k++) begin
                vld_q[k] <= 1'b0;
                idx_q[k] <= '0;
            end
        end else if (adv) begin
            vld_q[0] <= launch;
            idx_q[0] <= launch_idx;
            for (int k = 1; k < LAT; k++) begin
                vld_q[k] <= vld_q[k-1];
                idx_q[k] <= idx_q[k-1];
            end
        end
    end

    // Output register: result holds steady while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sad_valid_q <= 1'b0;
            sad_q       <= '0;
            sad_idx_q   <= '0;
        end else if (adv) begin
            sad_valid_q <= vld_q[LAT-1];
            sad_q       <= tree_sum;
            sad_idx_q   <= idx_q[LAT-1];
        end
    end

`ifdef ME_MIN_TRACK_EN
    logic [SAD_W-1:0] best_sad_q;
    logic [IDX_W-1:0] best_idx_q;

    // Running minimum over accepted SADs; candidate 0 reloads, ties keep the earlier index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            best_sad_q <= '0;
            best_idx_q <= '0;
        end else if (sad_hs && ((sad_idx_q == '0) || (sad_q < best_sad_q))) begin
            best_sad_q <= sad_q;
            best_idx_q <= sad_idx_q;
        end
    end

    assign best_sad = best_sad_q;
    assign best_idx = best_idx_q;
`endif

    assign sad_valid = sad_valid_q;
    assign sad       = sad_q;
    assign sad_idx   = sad_idx_q;
    assign busy      = (state_q != IDLE);
    assign done      = done_q;

endmodule

// File: tb/tb_me_sad_array.sv
// tb_me_sad_array: directed self-checking bench for me_sad_array (default parameters).
module tb_me_sad_array;

    localparam int BLK   = 16;
    localparam int PW    = 8;
    localparam int SMAX  = 48;
    localparam int SAD_W = 16;
    localparam int IDX_W = 6;
    localparam int CFG_W = 6;
    localparam int LAT   = 10;
    localparam int RW    = BLK * PW;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [CFG_W-1:0] cfg_srch_rows;
    logic             cur_valid;
    logic             cur_ready;
    logic [RW-1:0]    cur_row;
    logic             srch_valid;
    logic             srch_ready;
    logic [RW-1:0]    srch_row;
    logic             sad_valid;
    logic             sad_ready;
    logic [SAD_W-1:0] sad;
    logic [IDX_W-1:0] sad_idx;
`ifdef ME_MIN_TRACK_EN
    logic [SAD_W-1:0] best_sad;
    logic [IDX_W-1:0] best_idx;
`endif
    logic             busy;
    logic             done;

    int n_checks = 0;
    int n_fail   = 0;

    logic [RW-1:0] cur_mem  [BLK];
    logic [RW-1:0] srch_mem [SMAX];
    int            exp_sad[$];
    int            exp_best_sad;
    int            exp_best_idx;

    me_sad_array dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .cfg_srch_rows (cfg_srch_rows),
        .cur_valid     (cur_valid),
        .cur_ready     (cur_ready),
        .cur_row       (cur_row),
        .srch_valid    (srch_valid),
        .srch_ready    (srch_ready),
        .srch_row      (srch_row),
        .sad_valid     (sad_valid),
        .sad_ready     (sad_ready),
        .sad           (sad),
        .sad_idx       (sad_idx),
`ifdef ME_MIN_TRACK_EN
        .best_sad      (best_sad),
        .best_idx      (best_idx),
`endif
        .busy          (busy),
        .done          (done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: summary not reached, got time %0t required earlier", $time);
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [RW-1:0] row_all(input int v);
        logic [RW-1:0] r;
        for (int i = 0; i < BLK; i++) r[i*PW +: PW] = PW'(v);
        return r;
    endfunction

    // Row whose first n pixels are 100, the rest 0 (row total n*100).
    function automatic logic [RW-1:0] row_n100(input int n);
        logic [RW-1:0] r;
        r = '0;
        for (int i = 0; i < n; i++) r[i*PW +: PW] = PW'(100);
        return r;
    endfunction

    task automatic load_flat(input int cur_v, input int srch_v);
        for (int i = 0; i < BLK; i++)  cur_mem[i]  = row_all(cur_v);
        for (int i = 0; i < SMAX; i++) srch_mem[i] = row_all(srch_v);
    endtask

    // Runs one search from start to done. Called and returning at a negedge.
    // stall_len: cycles sad_ready is held low after the first SAD handshake.
    // abort_sads: leave the loop after that many SADs (no done expected), -1 for a full run.
    task automatic run_case(input string tag, input int cfg, input int stall_len,
                            input int abort_sads, input int chk_lat);
        int  rows, cur_i, srch_i, got, acc_it, first_v_it, first_hs_it, last_hs_it, stall_left;
        bit  stalled_prev, seen_done;
        logic [SAD_W-1:0] prev_sad;
        logic [IDX_W-1:0] prev_idx;
        rows = (cfg < BLK) ? BLK : ((cfg > SMAX) ? SMAX : cfg);
        cur_i = 0; srch_i = 0; got = 0; acc_it = -1; first_v_it = -1;
        first_hs_it = -1; last_hs_it = -1; stall_left = 0;
        stalled_prev = 1'b0; seen_done = 1'b0; prev_sad = '0; prev_idx = '0;

        start = 1'b1;
        cfg_srch_rows = CFG_W'(cfg);
        @(negedge clk);
        start = 1'b0;
        check({tag, " busy after start"}, busy, 1);

        for (int it = 0; it < 600; it++) begin
            if (done) begin
                seen_done = 1'b1;
                check({tag, " done one cycle after last handshake"}, it, last_hs_it + 1);
                check({tag, " busy low at done"}, busy, 0);
`ifdef ME_MIN_TRACK_EN
                check({tag, " best_sad"}, best_sad, exp_best_sad);
                check({tag, " best_idx"}, best_idx, exp_best_idx);
`endif
                break;
            end
            sad_ready  = (stall_left == 0);
            if (stall_left > 0) stall_left--;
            cur_valid  = (cur_i < BLK);
            cur_row    = cur_valid ? cur_mem[cur_i] : '0;
            srch_valid = (srch_i < rows);
            srch_row   = srch_valid ? srch_mem[srch_i] : '0;
            #1;
            if (it == 0) begin
                check({tag, " cur_ready in LOAD_CUR"}, cur_ready, 1);
                check({tag, " srch_ready in LOAD_CUR"}, srch_ready, 0);
            end
            if (stalled_prev) begin
                check({tag, " valid held in stall"}, sad_valid, 1);
                check({tag, " sad held in stall"}, sad, prev_sad);
                check({tag, " idx held in stall"}, sad_idx, prev_idx);
            end
            if (sad_valid && !sad_ready) begin
                check({tag, " srch_ready low in stall"}, srch_ready, 0);
                stalled_prev = 1'b1;
                prev_sad = sad;
                prev_idx = sad_idx;
            end else begin
                stalled_prev = 1'b0;
            end
            if (cur_valid && cur_ready) cur_i++;
            if (srch_valid && srch_ready) begin
                if (srch_i == BLK - 1) acc_it = it;
                srch_i++;
            end
            if (sad_valid && first_v_it < 0) first_v_it = it;
            if (sad_valid && sad_ready) begin
                if (got < exp_sad.size()) begin
                    check($sformatf("%s sad[%0d]", tag, got), sad, exp_sad[got]);
                    check($sformatf("%s sad_idx[%0d]", tag, got), sad_idx, got);
                end else begin
                    check({tag, " unexpected extra sad"}, got, exp_sad.size());
                end
                if (got == 0) begin
                    stall_left = stall_len;
                    first_hs_it = it;
                end
                got++;
                last_hs_it = it;
                if (got == abort_sads) break;
            end
            @(negedge clk);
        end

        if (abort_sads < 0) begin
            check({tag, " run reached done"}, seen_done, 1);
            check({tag, " sad count"}, got, exp_sad.size());
            // Accept edge of the 16th search row is the edge after iteration acc_it;
            // sad_valid becomes visible at the negedge after edge acc_it+LAT.
            if (chk_lat != 0)
                check({tag, " latency edges"}, first_v_it - acc_it - 1, LAT);
            if (stall_len == 0)
                check({tag, " back-to-back sads"}, last_hs_it - first_hs_it, exp_sad.size() - 1);
            cur_valid  = 1'b0;
            srch_valid = 1'b0;
            @(negedge clk);
            check({tag, " done is a single pulse"}, done, 0);
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; cfg_srch_rows = '0;
        cur_valid = 1'b0; cur_row = '0; srch_valid = 1'b0; srch_row = '0;
        sad_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("reset sad_valid", sad_valid, 0);
        check("reset sad", sad, 0);
        check("reset sad_idx", sad_idx, 0);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset cur_ready", cur_ready, 0);
        check("reset srch_ready", srch_ready, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Flat match: identical blocks, single candidate.
        load_flat(10, 10);
        exp_sad = {0};
        exp_best_sad = 0; exp_best_idx = 0;
        run_case("flat", 16, 0, -1, 1);

        // Ramp: search row r is all r -> SAD_v = 16*sum(v..v+15) = 1920 + 256v.
        for (int i = 0; i < BLK; i++)  cur_mem[i]  = row_all(0);
        for (int i = 0; i < SMAX; i++) srch_mem[i] = row_all(i);
        exp_sad = {1920, 2176, 2432};
        exp_best_sad = 1920; exp_best_idx = 0;
        run_case("ramp", 18, 0, -1, 1);

        // Max width: 256 pixels of |255-0|.
        load_flat(255, 0);
        exp_sad = {65280};
        exp_best_sad = 65280; exp_best_idx = 0;
        run_case("max", 16, 0, -1, 0);

        // Backpressure with candidates 900,400,700,400,500.
        // Row totals: r0=600 r2=300 r16=100 r17=300 r19=100, all others 0.
        load_flat(0, 0);
        srch_mem[0]  = row_n100(6);
        srch_mem[2]  = row_n100(3);
        srch_mem[16] = row_n100(1);
        srch_mem[17] = row_n100(3);
        srch_mem[19] = row_n100(1);
        exp_sad = {900, 400, 700, 400, 500};
        exp_best_sad = 400; exp_best_idx = 1;
        run_case("bp", 20, 5, -1, 0);

        // Reset mid-SEARCH: leave after two SADs while search rows still stream.
        load_flat(3, 5);
        exp_sad = {512, 512};
        run_case("abort", 40, 0, 2, 0);
        @(negedge clk);
        check("abort busy before reset", busy, 1);
        check("abort sad_valid before reset", sad_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort sad_valid in reset", sad_valid, 0);
        check("abort sad in reset", sad, 0);
        check("abort sad_idx in reset", sad_idx, 0);
        check("abort busy in reset", busy, 0);
        check("abort srch_ready in reset", srch_ready, 0);
        cur_valid = 1'b0; srch_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("abort no done in reset", done, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("abort no done after reset", done, 0);

        // Clamp: cfg=3 behaves as 16 rows, one candidate.
        exp_sad = {512};
        exp_best_sad = 512; exp_best_idx = 0;
        run_case("clamp", 3, 0, -1, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
